usb_stream_out: RTL and testbench

FX3 synchronous slave-FIFO reader: pulls host-to-FPGA (OUT endpoint) words from the FX3 consumer socket and presents them downstream with valid/ready flow control. Companion to `usb_stream_in`, which writes FPGA-to-host. Both share the same GPIF pins and are selected by `master_mode`. Sits between the FX3 pad ring and the command/stream consumers in the DVI design.

---
 rtl/usb_fx3_pkg.sv | 21 ++
 rtl/usb_rx_fifo.sv | 55 +++++
 rtl/usb_stream_out.sv | 153 +++++++++++++++
 tb/tb_usb_stream_out.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/usb_fx3_pkg.sv
// Shared FX3 GPIF definitions: master-mode encodings, socket addresses and the
// stream-out FSM state encoding.
package usb_fx3_pkg;

    localparam logic [2:0] MODE_STREAM_IN  = 3'b010;
    localparam logic [2:0] MODE_STREAM_OUT = 3'b011;
    localparam logic [2:0] MODE_IDLE       = 3'b101;

    localparam logic [1:0] SOCK_PROD = 2'b00;
    localparam logic [1:0] SOCK_CONS = 2'b11;

    localparam int DEFAULT_RD_LATENCY = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_WAIT  = 2'b01,
        ST_READ  = 2'b10,
        ST_DRAIN = 2'b11
    } out_state_e;

endpackage

// File: rtl/usb_rx_fifo.sv
// First-word-fall-through receive FIFO; exposes the free-slot count so the
// reader can reserve space for words still travelling through the FX3 pipe.
module usb_rx_fifo #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 16
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [DATA_W-1:0]        push_data,
    input  logic                     pop,
    output logic [DATA_W-1:0]        head,
    output logic                     valid,
    output logic [$clog2(DEPTH):0]   free
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DATA_W-1:0] mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [CW-1:0]     count;
    logic              do_pop;

    assign valid  = (count != '0);
    assign do_pop = pop && valid;
    assign head   = mem[rd_ptr];
    assign free   = CW'(DEPTH) - count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push)   wr_ptr <= wr_ptr + AW'(1);
            if (do_pop) rd_ptr <= rd_ptr + AW'(1);
            case ({push, do_pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // Storage carries data only, so it is left out of reset.
    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(push && !do_pop && (count == CW'(DEPTH))));

endmodule

// File: rtl/usb_stream_out.sv
// FX3 slave-FIFO reader: drains the consumer socket into a local FIFO and
// hands words downstream with valid/ready.
module usb_stream_out
    import usb_fx3_pkg::*;
#(
    parameter int read_watermark = 4,
    parameter int RD_LATENCY     = DEFAULT_RD_LATENCY,
    parameter int FIFO_DEPTH     = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [2:0]  master_mode,
    input  logic        FLAGC,
    input  logic        FLAGD,
    input  logic [31:0] DQ,
    output logic        SLCS,
    output logic        SLOE,
    output logic        SLRD,
    output logic        SLWR,
    output logic        PKTEND,
    output logic [1:0]  A,
    output logic [31:0] data_out,
    output logic        data_out_valid,
    input  logic        data_out_ready,
    output logic [1:0]  current_stream_out_mode
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
    localparam int TW = $clog2(read_watermark) + 1;
    localparam int DW = $clog2(RD_LATENCY + 1) + 1;

    out_state_e            state, state_nx;
    logic [TW-1:0]         tail_cnt, tail_nx;
    logic                  in_tail, in_tail_nx;
    logic [DW-1:0]         drain_cnt, drain_nx;
    logic                  rd_issue;
    logic [RD_LATENCY-1:0] pipe;
    logic [CW-1:0]         free;
    logic [CW-1:0]         inflight;
    logic                  room;

    function automatic logic [CW-1:0] count_ones(input logic [RD_LATENCY-1:0] v);
        logic [CW-1:0] n;
        n = '0;
        for (int i = 0; i < RD_LATENCY; i++) n = n + CW'(v[i]);
        return n;
    endfunction

    // Every read already issued owns a slot, so only space beyond those is usable.
    assign inflight = count_ones(pipe);
    assign room     = (free > inflight);

    always_comb begin
        state_nx   = state;
        tail_nx    = tail_cnt;
        in_tail_nx = in_tail;
        drain_nx   = drain_cnt;
        rd_issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (master_mode == MODE_STREAM_OUT) state_nx = ST_WAIT;
            end
            ST_WAIT: begin
                if (master_mode != MODE_STREAM_OUT) begin
                    state_nx = ST_IDLE;
                end else if (FLAGC && room) begin
                    state_nx   = ST_READ;
                    rd_issue   = 1'b1;
                    in_tail_nx = !FLAGD;
                    tail_nx    = FLAGD ? TW'(read_watermark - 1) : '0;
                end
            end
            ST_READ: begin
                if (!FLAGC) begin
                    state_nx = ST_DRAIN;
                    drain_nx = DW'(RD_LATENCY);
                end else if (in_tail || !FLAGD) begin
                    // The read on the bus when FLAGD drops is part of the tail.
                    in_tail_nx = 1'b1;
                    if (tail_cnt == '0) begin
                        state_nx = ST_DRAIN;
                        drain_nx = DW'(RD_LATENCY);
                    end else if (room) begin
                        rd_issue = 1'b1;
                        tail_nx  = tail_cnt - TW'(1);
                    end
                end else if (room) begin
                    rd_issue = 1'b1;
                end
            end
            ST_DRAIN: begin
                if (drain_cnt == '0)
                    state_nx = (master_mode == MODE_STREAM_OUT) ? ST_WAIT : ST_IDLE;
                else
                    drain_nx = drain_cnt - DW'(1);
            end
            default: state_nx = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            tail_cnt  <= '0;
            in_tail   <= 1'b0;
            drain_cnt <= '0;
            SLCS      <= 1'b1;
            SLOE      <= 1'b1;
            SLRD      <= 1'b1;
            SLWR      <= 1'b1;
            PKTEND    <= 1'b1;
            A         <= SOCK_CONS;
        end else begin
            state     <= state_nx;
            tail_cnt  <= tail_nx;
            in_tail   <= in_tail_nx;
            drain_cnt <= drain_nx;
            SLCS      <= (state_nx == ST_IDLE);
            SLOE      <= (state_nx == ST_IDLE);
            SLRD      <= !rd_issue;
            SLWR      <= 1'b1;
            PKTEND    <= 1'b1;
            A         <= SOCK_CONS;
        end
    end

    // Latency pipe: its last stage marks the edge on which DQ holds a requested word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pipe <= '0;
        end else begin
            pipe[0] <= rd_issue;
            for (int i = 1; i < RD_LATENCY; i++) pipe[i] <= pipe[i-1];
        end
    end

    usb_rx_fifo #(
        .DATA_W (32),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (pipe[RD_LATENCY-1]),
        .push_data (DQ),
        .pop       (data_out_ready),
        .head      (data_out),
        .valid     (data_out_valid),
        .free      (free)
    );

    assign current_stream_out_mode = state;

endmodule

// File: tb/tb_usb_stream_out.sv
// Bench for usb_stream_out: an FX3 consumer-socket model serves numbered words
// and a queue scoreboard checks every word handed downstream.
module tb_usb_stream_out;
    import usb_fx3_pkg::*;

    localparam int RD_LAT = 2;
    localparam int WM     = 4;
    localparam int DEPTH  = 16;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [2:0]  master_mode;
    logic        flagc, flagd;
    logic [31:0] dq;
    logic        slcs, sloe, slrd, slwr, pktend;
    logic [1:0]  a;
    logic [31:0] data_out;
    logic        data_out_valid;
    logic        data_out_ready;
    logic [1:0]  mode_state;

    int checks = 0;
    int errors = 0;
    int slrd_lows = 0;
    int cyc = 0;
    logic [31:0]       exp_q[$];
    logic [RD_LAT-1:0] hist = '0;
    logic [31:0]       word = 32'h10;

    always #5 clk = ~clk;

    usb_stream_out #(
        .read_watermark (WM),
        .RD_LATENCY     (RD_LAT),
        .FIFO_DEPTH     (DEPTH)
    ) dut (
        .clk                     (clk),
        .rst_n                   (rst_n),
        .master_mode             (master_mode),
        .FLAGC                   (flagc),
        .FLAGD                   (flagd),
        .DQ                      (dq),
        .SLCS                    (slcs),
        .SLOE                    (sloe),
        .SLRD                    (slrd),
        .SLWR                    (slwr),
        .PKTEND                  (pktend),
        .A                       (a),
        .data_out                (data_out),
        .data_out_valid          (data_out_valid),
        .data_out_ready          (data_out_ready),
        .current_stream_out_mode (mode_state)
    );

    // One clock: scoreboard pop on handshakes, FX3 model answers SLRD after RD_LAT edges.
    task automatic tick();
        logic [31:0] e;
        @(negedge clk);
        if (data_out_valid && data_out_ready) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_extra_word: got %h, required no word", data_out);
            end else begin
                e = exp_q.pop_front();
                if (data_out !== e) begin
                    errors++;
                    $display("FAIL sb_data: got %h, required %h", data_out, e);
                end
            end
        end
        if (slrd === 1'b0) slrd_lows++;
        hist = {hist[RD_LAT-2:0], (slrd === 1'b0)};
        if (hist[RD_LAT-1]) begin
            dq = word;
            exp_q.push_back(word);
            word++;
        end else begin
            dq = 32'hBAD0_0000 | cyc;
        end
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; master_mode = MODE_STREAM_OUT; flagc = 1'b0; flagd = 1'b0;
        data_out_ready = 1'b1; dq = '0;
        repeat (3) @(posedge clk);
        #1;
        checks++; if ({slcs, sloe, slrd} !== 3'b111) begin errors++; $display("FAIL reset_strobes: got %b, required 111", {slcs, sloe, slrd}); end
        checks++; if ({slwr, pktend} !== 2'b11) begin errors++; $display("FAIL reset_wr_pktend: got %b, required 11", {slwr, pktend}); end
        checks++; if (a !== 2'b11) begin errors++; $display("FAIL reset_addr: got %b, required 11", a); end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, required 0", data_out_valid); end
        checks++; if (mode_state !== 2'b00) begin errors++; $display("FAIL reset_state: got %b, required 00", mode_state); end
        rst_n = 1'b1;
        tick();
        checks++; if (mode_state !== 2'b01) begin errors++; $display("FAIL wait_state: got %b, required 01", mode_state); end
        checks++; if ({slcs, sloe, slrd} !== 3'b001) begin errors++; $display("FAIL wait_strobes: got %b, required 001", {slcs, sloe, slrd}); end
    endtask

    task automatic test_mode_change();
        master_mode = MODE_IDLE;
        tick();
        checks++; if (mode_state !== 2'b00) begin errors++; $display("FAIL mode_leave_state: got %b, required 00", mode_state); end
        checks++; if ({slcs, sloe} !== 2'b11) begin errors++; $display("FAIL mode_leave_strobes: got %b, required 11", {slcs, sloe}); end
        master_mode = MODE_STREAM_OUT;
        tick();
        checks++; if (mode_state !== 2'b01) begin errors++; $display("FAIL mode_return_state: got %b, required 01", mode_state); end
    endtask

    task automatic test_stream();
        int held;
        int drain;
        logic [7:0] lo_v;
        logic [1:0] st_last;
        word = 32'h10; flagc = 1'b1; flagd = 1'b1; data_out_ready = 1'b1;
        tick();
        checks++; if (slrd !== 1'b0 || mode_state !== 2'b10) begin errors++; $display("FAIL burst_start: got slrd=%b state=%b, required slrd=0 state=10", slrd, mode_state); end
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL burst_early_valid: got %b, required 0", data_out_valid); end
        tick();
        checks++; if (data_out_valid !== 1'b0) begin errors++; $display("FAIL burst_valid_t1: got %b, required 0", data_out_valid); end
        tick();
        checks++; if (data_out_valid !== 1'b1 || data_out !== 32'h10) begin errors++; $display("FAIL burst_first_word: got valid=%b data=%h, required valid=1 data=00000010", data_out_valid, data_out); end
        held = 0;
        repeat (6) begin
            tick();
            if (slrd === 1'b0) held++;
        end
        checks++; if (held !== 6) begin errors++; $display("FAIL burst_continuous: got %0d low cycles, required 6", held); end
        // FLAGD drops: four reads counted from this cycle, then DRAIN for RD_LAT+1 cycles.
        flagd = 1'b0;
        drain = 0;
        lo_v = '0;
        st_last = '0;
        for (int k = 0; k < 8; k++) begin
            lo_v[k] = (slrd === 1'b0);
            if (mode_state === 2'b11) drain++;
            st_last = mode_state;
            if (k == 4) flagc = 1'b0;
            if (k < 7) tick();
        end
        checks++; if (lo_v !== 8'b0000_1111) begin errors++; $display("FAIL tail_reads: got pattern %b, required 00001111", lo_v); end
        checks++; if (drain !== RD_LAT + 1) begin errors++; $display("FAIL tail_drain_len: got %0d, required %0d", drain, RD_LAT + 1); end
        checks++; if (st_last !== 2'b01) begin errors++; $display("FAIL tail_back_to_wait: got %b, required 01", st_last); end
        repeat (5) tick();
        checks++; if (exp_q.size() !== 0 || data_out_valid !== 1'b0) begin errors++; $display("FAIL burst_flushed: got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), data_out_valid); end
    endtask

    task automatic test_short();
        logic [5:0] lo_v;
        logic [1:0] st [6];
        word = 32'h0080_0080; flagc = 1'b1; flagd = 1'b0; data_out_ready = 1'b1;
        tick();
        for (int k = 0; k < 6; k++) begin
            lo_v[k] = (slrd === 1'b0);
            st[k] = mode_state;
            if (k == 0) flagc = 1'b0;
            if (k == 2) begin
                checks++; if (data_out_valid !== 1'b1 || data_out !== 32'h0080_0080) begin errors++; $display("FAIL short_word: got valid=%b data=%h, required valid=1 data=00800080", data_out_valid, data_out); end
            end
            tick();
        end
        checks++; if (lo_v !== 6'b000001) begin errors++; $display("FAIL short_reads: got pattern %b, required 000001", lo_v); end
        checks++; if ({st[0], st[1], st[2], st[3], st[4]} !== 10'b10_11_11_11_01) begin
            errors++; $display("FAIL short_states: got %b %b %b %b %b, required 10 11 11 11 01", st[0], st[1], st[2], st[3], st[4]);
        end
        checks++; if (exp_q.size() !== 0 || data_out_valid !== 1'b0) begin errors++; $display("FAIL short_flushed: got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), data_out_valid); end
    endtask

    task automatic test_backpressure();
        int l0;
        bit done;
        word = 32'h1000; data_out_ready = 1'b0; flagc = 1'b1; flagd = 1'b1;
        l0 = slrd_lows;
        repeat (30) tick();
        checks++; if (slrd_lows - l0 !== DEPTH) begin errors++; $display("FAIL bp_read_count: got %0d reads, required %0d", slrd_lows - l0, DEPTH); end
        checks++; if (slrd !== 1'b1 || mode_state !== 2'b10) begin errors++; $display("FAIL bp_paused: got slrd=%b state=%b, required slrd=1 state=10", slrd, mode_state); end
        checks++; if (exp_q.size() !== DEPTH || data_out !== 32'h1000) begin errors++; $display("FAIL bp_full: got %0d words head=%h, required %0d words head=00001000", exp_q.size(), data_out, DEPTH); end
        repeat (40) begin
            data_out_ready = 1'($urandom_range(0, 1));
            tick();
        end
        data_out_ready = 1'b1;
        flagd = 1'b0;
        done = 1'b0;
        for (int i = 0; i < 100 && !done; i++) begin
            if (mode_state === 2'b11) flagc = 1'b0;
            if (mode_state === 2'b01 && flagc == 1'b0) done = 1'b1;
            else tick();
        end
        checks++; if (!done) begin errors++; $display("FAIL bp_tail_timeout: got state=%b, required 01 within 100 cycles", mode_state); end
        repeat (20) tick();
        checks++; if (exp_q.size() !== 0 || data_out_valid !== 1'b0) begin errors++; $display("FAIL bp_flushed: got %0d pending valid=%b, required 0 pending valid=0", exp_q.size(), data_out_valid); end
    endtask

    task automatic test_reset_mid();
        word = 32'h2000; data_out_ready = 1'b0; flagc = 1'b1; flagd = 1'b1;
        for (int i = 0; i < 50 && exp_q.size() < 5; i++) tick();
        checks++; if (exp_q.size() !== 5 || mode_state !== 2'b10) begin errors++; $display("FAIL rstmid_setup: got %0d words state=%b, required 5 words state=10", exp_q.size(), mode_state); end
        #2 rst_n = 1'b0;
        #1;
        checks++; if ({slcs, sloe, slrd, slwr, pktend} !== 5'b11111 || a !== 2'b11) begin errors++; $display("FAIL rstmid_outputs: got %b a=%b, required 11111 a=11", {slcs, sloe, slrd, slwr, pktend}, a); end
        checks++; if (data_out_valid !== 1'b0 || mode_state !== 2'b00) begin errors++; $display("FAIL rstmid_state: got valid=%b state=%b, required valid=0 state=00", data_out_valid, mode_state); end
        exp_q.delete();
        hist = '0;
        flagc = 1'b0; flagd = 1'b0; data_out_ready = 1'b1;
        tick();
        rst_n = 1'b1;
        tick();
        checks++; if (mode_state !== 2'b01 || data_out_valid !== 1'b0) begin errors++; $display("FAIL rstmid_recover: got state=%b valid=%b, required state=01 valid=0", mode_state, data_out_valid); end
        word = 32'h3000; flagc = 1'b1;
        tick();
        flagc = 1'b0;
        tick();
        tick();
        checks++; if (data_out_valid !== 1'b1 || data_out !== 32'h3000) begin errors++; $display("FAIL rstmid_fresh_word: got valid=%b data=%h, required valid=1 data=00003000", data_out_valid, data_out); end
        repeat (5) tick();
        checks++; if (exp_q.size() !== 0 || word !== 32'h3001) begin errors++; $display("FAIL rstmid_flushed: got %0d pending next=%h, required 0 pending next=00003001", exp_q.size(), word); end
    endtask

    initial begin
        test_reset();
        test_mode_change();
        test_stream();
        test_short();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
